// File: rtl/scan_chain_controller.sv
// Host-command sequencer for a two-phase scan chain: emits non-overlapping clk_p/clk_n,
// shifts CHAIN_LEN bits out of cmd_data and collects the bits returning on scan_out.
module scan_chain_controller #(
  parameter int CHAIN_LEN    = 8,
  parameter int PHASE_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 scan_clk_p,
  output logic                 scan_clk_n,
  output logic                 scan_en,
  output logic                 scan_update,
  output logic                 scan_reset
);

  localparam int SW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(PHASE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, TAIL, UPDATE, CHAIN_RST, RESP} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cyc, cyc_n;
  logic [1:0]             ph, ph_n;
  logic [SW-1:0]          slot, slot_n;
  logic [1:0]             op_q;
  logic [CHAIN_LEN-1:0]   data_q;
  logic [CHAIN_LEN-1:0]   data_src;
  logic [CHAIN_LEN-1:0]   data_shifted;
  logic                   last_cyc;
  logic                   accept;
  logic                   sample;
  logic                   scan_in_nx, clk_p_nx, clk_n_nx, en_nx, update_nx, reset_nx;

  assign last_cyc = (cyc == CW'(PHASE_CYCLES - 1));
  assign accept   = (state == IDLE) && cmd_valid;
  assign sample   = (state == SHIFT) && (ph == 2'd0) && last_cyc;

  // Slot counter advances once per full four-phase slot; phase wraps 3 -> 0 in two bits.
  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    ph_n    = ph;
    slot_n  = slot;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00, 2'b01: state_n = SHIFT;
            2'b10:        state_n = CHAIN_RST;
            default:      state_n = RESP;
          endcase
        end
      end
      SHIFT: begin
        if (last_cyc) begin
          cyc_n = '0;
          ph_n  = ph + 2'd1;
          if (ph == 2'd3) begin
            if (slot == SW'(CHAIN_LEN - 1)) state_n = TAIL;
            else slot_n = slot + SW'(1);
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      TAIL: begin
        if (last_cyc) state_n = (op_q == 2'b00) ? UPDATE : RESP;
        else cyc_n = cyc + CW'(1);
      end
      UPDATE, CHAIN_RST: begin
        if (last_cyc) state_n = RESP;
        else cyc_n = cyc + CW'(1);
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) begin
      cyc_n  = '0;
      ph_n   = 2'd0;
      slot_n = '0;
    end
  end

  // Pin values are decoded from the next state so the registered outputs line up with it.
  assign data_src     = (state == IDLE) ? cmd_data : data_q;
  assign data_shifted = data_src >> slot_n;

  always_comb begin
    scan_in_nx = (state_n == SHIFT) && data_shifted[0];
    clk_p_nx   = (state_n == SHIFT) && (ph_n == 2'd1);
    clk_n_nx   = (state_n == SHIFT) && (ph_n == 2'd3);
    en_nx      = (state_n == SHIFT) || (state_n == TAIL);
    update_nx  = (state_n == UPDATE);
    reset_nx   = (state_n == CHAIN_RST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cyc         <= '0;
      ph          <= 2'd0;
      slot        <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
      busy        <= 1'b0;
      scan_in     <= 1'b0;
      scan_clk_p  <= 1'b0;
      scan_clk_n  <= 1'b0;
      scan_en     <= 1'b0;
      scan_update <= 1'b0;
      scan_reset  <= 1'b0;
    end else begin
      state       <= state_n;
      cyc         <= cyc_n;
      ph          <= ph_n;
      slot        <= slot_n;
      cmd_ready   <= (state_n == IDLE);
      rsp_valid   <= (state_n == RESP);
      busy        <= (state_n != IDLE);
      scan_in     <= scan_in_nx;
      scan_clk_p  <= clk_p_nx;
      scan_clk_n  <= clk_n_nx;
      scan_en     <= en_nx;
      scan_update <= update_nx;
      scan_reset  <= reset_nx;
      if (accept) begin
        rsp_data <= '0;
        rsp_err  <= (cmd_op == 2'b11);
      end else if (sample) begin
        rsp_data <= rsp_data | (CHAIN_LEN'(scan_out) << slot);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      op_q   <= cmd_op;
      data_q <= cmd_data;
    end
  end

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: two instances (P=1 and P=3) each driving a pin-level
// two-phase chain model, checked against a command-level reference of chain/shadow contents.
module tb_scan_chain_controller;
  localparam int N = 8;

  logic clock = 1'b0;
  logic rst = 1'b1;
  always #5 clock = ~clock;

  logic         cv[2], cr[2], rv[2], rr[2], re[2], bz[2];
  logic         si[2], so[2], sp[2], sn[2], se[2], su[2], sr[2];
  logic [1:0]   opv[2];
  logic [N-1:0] cd[2], rd[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    scan_chain_controller #(.CHAIN_LEN(N), .PHASE_CYCLES(g == 0 ? 1 : 3)) dut (
      .clock(clock), .reset(rst),
      .cmd_valid(cv[g]), .cmd_ready(cr[g]), .cmd_op(opv[g]), .cmd_data(cd[g]),
      .rsp_valid(rv[g]), .rsp_ready(rr[g]), .rsp_data(rd[g]), .rsp_err(re[g]),
      .busy(bz[g]), .scan_in(si[g]), .scan_out(so[g]),
      .scan_clk_p(sp[g]), .scan_clk_n(sn[g]), .scan_en(se[g]),
      .scan_update(su[g]), .scan_reset(sr[g])
    );
  end

  function automatic int phc(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Pin-level chain: clk_p rise loads the master stage, clk_n rise moves it into the cells.
  logic [N-1:0] chain[2], mstr[2], shadow[2];
  logic         p_q[2], n_q[2], su_q[2], si_q[2], seenp[2];
  logic         rst_q;
  int           viol[2], pw_err[2], runp[2], runn[2], upd_cyc[2], rst_cyc[2], act[2];
  int           cnt = 0;

  assign so[0] = chain[0][0];
  assign so[1] = chain[1][0];

  always @(posedge clock) cnt <= cnt + 1;

  always @(posedge clock) begin
    rst_q <= rst;
    for (int u = 0; u < 2; u++) begin
      p_q[u]  <= sp[u];
      n_q[u]  <= sn[u];
      su_q[u] <= su[u];
      si_q[u] <= si[u];
      if (cnt < 2) begin
        chain[u] <= '0; mstr[u] <= '0; shadow[u] <= '0; seenp[u] <= 1'b0;
        viol[u] <= 0; pw_err[u] <= 0; runp[u] <= 0; runn[u] <= 0;
        upd_cyc[u] <= 0; rst_cyc[u] <= 0; act[u] <= 0;
      end else begin
        if (sp[u] && !p_q[u]) mstr[u] <= {si[u], chain[u][N-1:1]};
        if (sn[u] && !n_q[u]) chain[u] <= mstr[u];
        if (su[u] && !su_q[u]) shadow[u] <= chain[u];
        if (sr[u]) begin
          chain[u]  <= '0;
          shadow[u] <= '0;
        end
        upd_cyc[u] <= upd_cyc[u] + int'(su[u]);
        rst_cyc[u] <= rst_cyc[u] + int'(sr[u]);
        act[u]     <= act[u] + int'(sp[u] | sn[u] | se[u] | su[u] | sr[u] | si[u]);
        viol[u] <= viol[u] + int'(sp[u] && sn[u])
                           + int'((sp[u] != p_q[u]) && (sn[u] != n_q[u]))
                           + int'((si[u] != si_q[u]) && (sp[u] || sn[u] || seenp[u]) && !rst_q);
        seenp[u] <= rst_q ? 1'b0 : (sp[u] ? 1'b1 : (sn[u] ? 1'b0 : seenp[u]));
        runp[u] <= sp[u] ? runp[u] + 1 : 0;
        runn[u] <= sn[u] ? runn[u] + 1 : 0;
        pw_err[u] <= pw_err[u]
                   + int'(!sp[u] && runp[u] != 0 && runp[u] != phc(u) && !rst_q)
                   + int'(!sn[u] && runn[u] != 0 && runn[u] != phc(u) && !rst_q);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, a, e);
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] data;
    logic [N-1:0] rsp;
    logic         err;
    int           lat;
    int           upd;
    int           rcyc;
    logic [N-1:0] shadow;
    int           hold;
    logic         quiet;
  } vec_t;

  // Command-level reference: a shift returns the old chain contents and leaves the new data.
  logic [N-1:0] ref_chain[2] = '{'0, '0};
  logic [N-1:0] ref_shadow[2] = '{'0, '0};

  function automatic vec_t predict(input int u, input logic [1:0] op, input logic [N-1:0] data);
    vec_t v;
    int p = phc(u);
    v.op = op; v.data = data; v.rsp = ref_chain[u]; v.err = 1'b0;
    v.upd = 0; v.rcyc = 0; v.hold = 0; v.quiet = 1'b0;
    case (op)
      2'b00: begin
        v.lat = p * (4 * N + 2); v.upd = p;
        ref_chain[u] = data; ref_shadow[u] = data;
      end
      2'b01: begin
        v.lat = p * (4 * N + 1);
        ref_chain[u] = data;
      end
      2'b10: begin
        v.lat = p; v.rsp = '0; v.rcyc = p;
        ref_chain[u] = '0; ref_shadow[u] = '0;
      end
      default: begin
        v.lat = 0; v.rsp = '0; v.err = 1'b1; v.quiet = 1'b1;
      end
    endcase
    v.shadow = ref_shadow[u];
    return v;
  endfunction

  task automatic run(input int u, input vec_t v);
    int e0, ub, rb, ab, n, lat;
    @(negedge clock);
    chk("cmd_ready_idle", 32'(cr[u]), 32'd1);
    ub = upd_cyc[u]; rb = rst_cyc[u]; ab = act[u];
    cv[u] = 1'b1; opv[u] = v.op; cd[u] = v.data;
    @(posedge clock);
    #1;
    cv[u] = 1'b0;
    e0 = cnt;
    n = 0;
    @(negedge clock);
    while (rv[u] !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (rv[u] !== 1'b1) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      lat = -1;
    end else begin
      lat = cnt - e0;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("rsp_data", 32'(rd[u]), 32'(v.rsp));
    chk("rsp_err", 32'(re[u]), 32'(v.err));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clock);
      chk("hold_valid", 32'(rv[u]), 32'd1);
      chk("hold_data", 32'(rd[u]), 32'(v.rsp));
      chk("hold_err", 32'(re[u]), 32'(v.err));
      chk("hold_cmd_ready", 32'(cr[u]), 32'd0);
    end
    rr[u] = 1'b1;
    @(posedge clock);
    #1;
    rr[u] = 1'b0;
    @(negedge clock);
    chk("idle_after_rsp", 32'({cr[u], rv[u], bz[u]}), 32'b100);
    chk("update_cycles", 32'(upd_cyc[u] - ub), 32'(v.upd));
    chk("chain_reset_cycles", 32'(rst_cyc[u] - rb), 32'(v.rcyc));
    chk("shadow", 32'(shadow[u]), 32'(v.shadow));
    if (v.quiet) chk("reserved_no_scan_activity", 32'(act[u] - ab), 32'd0);
  endtask

  vec_t tbl[8];
  vec_t v;

  initial begin
    for (int u = 0; u < 2; u++) begin
      cv[u] = 1'b0; rr[u] = 1'b0; opv[u] = 2'b00; cd[u] = '0;
    end
    tbl[0] = '{2'b00, 8'hA5, 8'h00, 1'b0, 34, 1, 0, 8'hA5, 0,  1'b0};
    tbl[1] = '{2'b00, 8'h3C, 8'hA5, 1'b0, 34, 1, 0, 8'h3C, 3,  1'b0};
    tbl[2] = '{2'b00, 8'h12, 8'h3C, 1'b0, 34, 1, 0, 8'h12, 0,  1'b0};
    tbl[3] = '{2'b01, 8'hFF, 8'h12, 1'b0, 33, 0, 0, 8'h12, 0,  1'b0};
    tbl[4] = '{2'b00, 8'hF0, 8'hFF, 1'b0, 34, 1, 0, 8'hF0, 0,  1'b0};
    tbl[5] = '{2'b10, 8'hAA, 8'h00, 1'b0, 1,  0, 1, 8'h00, 0,  1'b0};
    tbl[6] = '{2'b01, 8'h5A, 8'h00, 1'b0, 33, 0, 0, 8'h00, 0,  1'b0};
    tbl[7] = '{2'b11, 8'h77, 8'h00, 1'b1, 0,  0, 0, 8'h00, 10, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset_cmd_ready", 32'(cr[u]), 32'd1);
      chk("reset_rsp_flags", 32'({rv[u], re[u], bz[u]}), 32'd0);
      chk("reset_scan_pins", 32'({si[u], sp[u], sn[u], se[u], su[u], sr[u]}), 32'd0);
      chk("reset_rsp_data", 32'(rd[u]), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run(0, tbl[i]);
      void'(predict(0, tbl[i].op, tbl[i].data));
    end

    run(1, '{2'b00, 8'h81, 8'h00, 1'b0, 102, 3, 0, 8'h81, 0, 1'b0});
    void'(predict(1, 2'b00, 8'h81));

    // Abort a WRITE of 0x6B at the start of slot 4: four bits have entered the chain.
    @(negedge clock);
    chk("abort_cmd_ready_idle", 32'(cr[0]), 32'd1);
    cv[0] = 1'b1; opv[0] = 2'b00; cd[0] = 8'h6B;
    @(posedge clock);
    #1;
    cv[0] = 1'b0;
    repeat (16) @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    chk("abort_scan_pins", 32'({si[0], sp[0], sn[0], se[0], su[0], sr[0]}), 32'd0);
    chk("abort_cmd_ready", 32'(cr[0]), 32'd1);
    chk("abort_rsp_busy", 32'({rv[0], bz[0]}), 32'd0);
    repeat (3) begin
      @(negedge clock);
      chk("abort_no_rsp", 32'(rv[0]), 32'd0);
    end
    ref_chain[0] = N'((8'h6B << (N - 4)) | (ref_chain[0] >> 4));
    v = predict(0, 2'b00, 8'hC3);
    run(0, v);
    v = predict(0, 2'b01, 8'h00);
    run(0, v);

    for (int i = 0; i < 40; i++) begin
      int u;
      logic [1:0] op;
      logic [N-1:0] data;
      u = int'($urandom_range(1, 0));
      op = 2'($urandom_range(3, 0));
      data = N'($urandom);
      v = predict(u, op, data);
      v.hold = int'($urandom_range(2, 0));
      run(u, v);
    end

    for (int u = 0; u < 2; u++) begin
      chk("clock_overlap_or_scan_in_violations", 32'(viol[u]), 32'd0);
      chk("clock_pulse_width_errors", 32'(pw_err[u]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
